// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 32-bit-word data memory between the CPU
// load/store port (0) and the debug loader port (1), with registered responses.
module dmem_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req_valid_i,
  output logic          p0_req_ready_o,
  input  logic          p0_req_write_i,
  input  logic [31:0]   p0_req_addr_i,
  input  logic [31:0]   p0_req_wdata_i,
  output logic          p0_rsp_valid_o,
  output logic [31:0]   p0_rsp_rdata_o,
  output logic          p0_rsp_err_o,
  input  logic          p1_req_valid_i,
  output logic          p1_req_ready_o,
  input  logic          p1_req_write_i,
  input  logic [31:0]   p1_req_addr_i,
  input  logic [31:0]   p1_req_wdata_i,
  output logic          p1_rsp_valid_o,
  output logic [31:0]   p1_rsp_rdata_o,
  output logic          p1_rsp_err_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          mem_we_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          last_grant_o
);

  logic [1:0]       req_valid;
  logic [1:0]       req_write;
  logic [1:0]       req_ok;
  logic [1:0]       grant;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic             sel;

  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_err_q;
  logic [1:0][31:0] rsp_rdata_q;
  logic             last_grant_q;
  logic             last_grant_d;

  assign req_valid = {p1_req_valid_i, p0_req_valid_i};
  assign req_write = {p1_req_write_i, p0_req_write_i};
  assign req_addr  = {p1_req_addr_i,  p0_req_addr_i};
  assign req_wdata = {p1_req_wdata_i, p0_req_wdata_i};

  // A request is in range only if word aligned and inside the DEPTH-word window.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ok[gi] = (req_addr[gi][1:0] == 2'b00) &&
                        (req_addr[gi][31:AW+2] == '0);
  end

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (req_valid == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  assign sel          = grant[1];
  assign last_grant_d = (|grant) ? sel : last_grant_q;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (|grant) begin
      mem_addr_o  = req_addr[sel][AW+1:2];
      mem_wdata_o = req_wdata[sel];
      mem_we_o    = req_write[sel] & req_ok[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp_rdata_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= grant;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_rdata_q[i] <= (req_ok[i] && !req_write[i]) ? mem_rdata_i : 32'd0;
          rsp_err_q[i]   <= ~req_ok[i];
        end
      end
    end
  end

  assign p0_req_ready_o = grant[0];
  assign p1_req_ready_o = grant[1];

  // Gating with reset drops a response that is due in the cycle reset rises.
  assign p0_rsp_valid_o = rsp_valid_q[0] & ~reset;
  assign p1_rsp_valid_o = rsp_valid_q[1] & ~reset;
  assign p0_rsp_rdata_o = rsp_rdata_q[0];
  assign p1_rsp_rdata_o = rsp_rdata_q[1];
  assign p0_rsp_err_o   = rsp_err_q[0];
  assign p1_rsp_err_o   = rsp_err_q[1];
  assign last_grant_o   = last_grant_q;

endmodule
